// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: opcode map, condition codes and
// the per-stage state records.
package exe_stage_pkg;

  localparam int unsigned DataW = 16;
  localparam int unsigned RegW  = 3;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpSet = 3'b010,
    OpXor = 3'b011,
    OpShl = 3'b100,
    OpShr = 3'b101,
    OpOr  = 3'b110,
    OpAnd = 3'b111
  } aluOp_e;

  // Condition codes are {N,Z,P}, one-hot
  localparam logic [2:0] CcN = 3'b100;
  localparam logic [2:0] CcZ = 3'b010;
  localparam logic [2:0] CcP = 3'b001;

  typedef struct packed {
    logic             valid;
    logic [DataW-1:0] src1;
    logic [DataW-1:0] src2;
    logic [RegW-1:0]  src1Reg;
    logic [RegW-1:0]  src2Reg;
    logic             useImm;
    logic [2:0]       opcode;
    logic             flagBit;
    logic [RegW-1:0]  dstReg;
    logic             wrEn;
  } eStage_t;

  typedef struct packed {
    logic             valid;
    logic [DataW-1:0] result;
    logic [RegW-1:0]  dstReg;
    logic             wrEn;
    logic [2:0]       ccode;
  } wStage_t;

  function automatic logic [2:0] calcCcode(input logic [DataW-1:0] value);
    if (value[DataW-1]) begin
      return CcN;
    end else if (value == '0) begin
      return CcZ;
    end
    return CcP;
  endfunction

endpackage

// File: rtl/exe_stage_fwd.sv
// Operand bypass: substitutes the W-stage result for a stale register-file
// operand when W is about to write that register.
module exe_fwd
  import exe_stage_pkg::*;
(
  input  logic             wValid_i,
  input  logic             wWrEn_i,
  input  logic [RegW-1:0]  wDstReg_i,
  input  logic [RegW-1:0]  srcReg_i,
  input  logic             fwdAllow_i,
  input  logic [DataW-1:0] srcData_i,
  input  logic [DataW-1:0] fwdData_i,
  output logic [DataW-1:0] operand_o
);

  logic hit;

  assign hit       = wValid_i & wWrEn_i & fwdAllow_i & (wDstReg_i == srcReg_i);
  assign operand_o = hit ? fwdData_i : srcData_i;

endmodule

// File: rtl/exe_stage.sv
// Two-entry execute pipeline (E: operands, W: result) around an external
// combinational ALU, with W-to-E forwarding and valid/ready handshakes.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  // decode side
  input  logic             i_valid,
  input  logic [2:0]       i_opcode,
  input  logic             i_flagBit,
  input  logic [RegW-1:0]  i_src1Reg,
  input  logic [RegW-1:0]  i_src2Reg,
  input  logic             i_useImm,
  input  logic [DataW-1:0] i_imm,
  input  logic [RegW-1:0]  i_dstReg,
  input  logic             i_wrEn,
  input  logic [DataW-1:0] i_src1Data,
  input  logic [DataW-1:0] i_src2Data,
  input  logic             i_flush,
  output logic             o_ready,
  // ALU side
  output logic [DataW-1:0] o_aluSrc1,
  output logic [DataW-1:0] o_aluSrc2,
  output logic [2:0]       o_aluOpcode,
  output logic             o_aluFlagBit,
  input  logic [DataW-1:0] i_aluResult,
  // writeback side
  output logic             o_valid,
  output logic [DataW-1:0] o_result,
  output logic [RegW-1:0]  o_dstReg,
  output logic             o_wrEn,
  output logic [2:0]       o_ccode,
  input  logic             i_ready
);

  eStage_t eQ, eD;
  wStage_t wQ, wD;
  logic    advE, accept, loadW;

  assign advE    = eQ.valid & (~wQ.valid | i_ready);
  assign o_ready = ~eQ.valid | advE;
  assign accept  = i_valid & o_ready & ~i_flush;
  // A flushed E item is dropped, never promoted into W
  assign loadW   = advE & ~i_flush;

  always_comb begin
    eD = eQ;
    if (accept) begin
      eD.valid   = 1'b1;
      eD.src1    = i_src1Data;
      eD.src2    = i_useImm ? i_imm : i_src2Data;
      eD.src1Reg = i_src1Reg;
      eD.src2Reg = i_src2Reg;
      eD.useImm  = i_useImm;
      eD.opcode  = i_opcode;
      eD.flagBit = i_flagBit;
      eD.dstReg  = i_dstReg;
      eD.wrEn    = i_wrEn;
    end else if (advE || i_flush) begin
      eD.valid = 1'b0;
    end
  end

  always_comb begin
    wD = wQ;
    if (loadW) begin
      wD.valid  = 1'b1;
      wD.result = i_aluResult;
      wD.dstReg = eQ.dstReg;
      wD.wrEn   = eQ.wrEn;
      wD.ccode  = calcCcode(i_aluResult);
    end else if (wQ.valid && i_ready) begin
      wD.valid = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      eQ       <= '0;
      wQ       <= '0;
      wQ.ccode <= CcZ;
    end else begin
      eQ <= eD;
      wQ <= wD;
    end
  end

  exe_fwd u_fwdSrc1 (
    .wValid_i  (wQ.valid),
    .wWrEn_i   (wQ.wrEn),
    .wDstReg_i (wQ.dstReg),
    .srcReg_i  (eQ.src1Reg),
    .fwdAllow_i(1'b1),
    .srcData_i (eQ.src1),
    .fwdData_i (wQ.result),
    .operand_o (o_aluSrc1)
  );

  // An immediate in src2 is never a register read, so it must not be bypassed
  exe_fwd u_fwdSrc2 (
    .wValid_i  (wQ.valid),
    .wWrEn_i   (wQ.wrEn),
    .wDstReg_i (wQ.dstReg),
    .srcReg_i  (eQ.src2Reg),
    .fwdAllow_i(~eQ.useImm),
    .srcData_i (eQ.src2),
    .fwdData_i (wQ.result),
    .operand_o (o_aluSrc2)
  );

  assign o_aluOpcode  = eQ.opcode;
  assign o_aluFlagBit = eQ.flagBit;

  assign o_valid  = wQ.valid;
  assign o_result = wQ.result;
  assign o_dstReg = wQ.dstReg;
  assign o_wrEn   = wQ.wrEn;
  assign o_ccode  = wQ.ccode;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: a behavioural ALU and register model predict
// each result at issue time; a monitor compares them as W hands them off.
module tb_exe_stage;
  import exe_stage_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid, i_flagBit, i_useImm, i_wrEn, i_flush, i_ready;
  logic [2:0]  i_opcode, i_src1Reg, i_src2Reg, i_dstReg;
  logic [15:0] i_imm, i_src1Data, i_src2Data, i_aluResult;
  logic        o_ready, o_aluFlagBit, o_valid, o_wrEn;
  logic [15:0] o_aluSrc1, o_aluSrc2, o_result;
  logic [2:0]  o_aluOpcode, o_dstReg, o_ccode;

  typedef struct packed {
    logic [15:0] result;
    logic [2:0]  dstReg;
    logic        wrEn;
    logic [2:0]  ccode;
  } exp_t;

  exp_t        expQ[$];
  int          errors    = 0;
  int          checks    = 0;
  int          delivered = 0;
  logic [15:0] rf[8];

  always #5 i_clk = ~i_clk;

  exe_stage dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_opcode    (i_opcode),
    .i_flagBit   (i_flagBit),
    .i_src1Reg   (i_src1Reg),
    .i_src2Reg   (i_src2Reg),
    .i_useImm    (i_useImm),
    .i_imm       (i_imm),
    .i_dstReg    (i_dstReg),
    .i_wrEn      (i_wrEn),
    .i_src1Data  (i_src1Data),
    .i_src2Data  (i_src2Data),
    .i_flush     (i_flush),
    .o_ready     (o_ready),
    .o_aluSrc1   (o_aluSrc1),
    .o_aluSrc2   (o_aluSrc2),
    .o_aluOpcode (o_aluOpcode),
    .o_aluFlagBit(o_aluFlagBit),
    .i_aluResult (i_aluResult),
    .o_valid     (o_valid),
    .o_result    (o_result),
    .o_dstReg    (o_dstReg),
    .o_wrEn      (o_wrEn),
    .o_ccode     (o_ccode),
    .i_ready     (i_ready)
  );

  function automatic logic [15:0] aluModel(input logic [2:0] op, input logic fb,
                                           input logic [15:0] a, input logic [15:0] b);
    case (op)
      OpAdd:   return a + b;
      OpSub:   return a - b;
      OpSet:   return b;
      OpXor:   return a ^ b;
      OpShl:   return a << b[3:0];
      OpShr:   return fb ? 16'($signed(a) >>> b[3:0]) : a >> b[3:0];
      OpOr:    return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [2:0] ccModel(input logic [15:0] r);
    if (r[15]) return 3'b100;
    if (r == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  always_comb i_aluResult = aluModel(o_aluOpcode, o_aluFlagBit, o_aluSrc1, o_aluSrc2);

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Handshake completes on the coming rising edge, so pop here
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      exp_t e;
      checkEq("item_expected", 32'(expQ.size() != 0), 1);
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkEq("result", o_result, e.result);
        checkEq("dstReg", o_dstReg, e.dstReg);
        checkEq("wrEn", o_wrEn, e.wrEn);
        checkEq("ccode", o_ccode, e.ccode);
        delivered++;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // stale[0]/[1]: drive 0 instead of the true register value, as a regfile
  // not yet written by an in-flight producer would
  task automatic issue(input logic [2:0] op, input logic fb, input logic [2:0] s1,
                       input logic [2:0] s2, input logic useImm, input logic [15:0] imm,
                       input logic [2:0] dst, input logic wrEn, input logic [1:0] stale);
    exp_t        e;
    logic [15:0] r;
    int          n;
    r          = aluModel(op, fb, rf[s1], useImm ? imm : rf[s2]);
    i_valid    = 1'b1;
    i_opcode   = op;
    i_flagBit  = fb;
    i_src1Reg  = s1;
    i_src2Reg  = s2;
    i_useImm   = useImm;
    i_imm      = imm;
    i_dstReg   = dst;
    i_wrEn     = wrEn;
    i_src1Data = stale[0] ? 16'h0000 : rf[s1];
    i_src2Data = stale[1] ? 16'h0000 : rf[s2];
    n = 0;
    @(negedge i_clk);
    while (!o_ready && n < 20) begin
      n++;
      @(negedge i_clk);
    end
    checkEq("accept", o_ready, 1);
    e = '{result: r, dstReg: dst, wrEn: wrEn, ccode: ccModel(r)};
    expQ.push_back(e);
    if (wrEn) rf[dst] = r;
    @(posedge i_clk);
    #1;
    // Garbage on the decode bus while idle must be ignored
    i_valid    = 1'b0;
    i_opcode   = 3'($urandom);
    i_src1Reg  = 3'($urandom);
    i_src2Reg  = 3'($urandom);
    i_dstReg   = 3'($urandom);
    i_wrEn     = 1'($urandom);
    i_src1Data = 16'($urandom);
    i_src2Data = 16'($urandom);
    i_imm      = 16'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] resA;
    i_rst = 1'b1;
    i_valid = 1'b0; i_opcode = '0; i_flagBit = 1'b0; i_src1Reg = '0; i_src2Reg = '0;
    i_useImm = 1'b0; i_imm = '0; i_dstReg = '0; i_wrEn = 1'b0;
    i_src1Data = '0; i_src2Data = '0; i_flush = 1'b0; i_ready = 1'b1;
    for (int i = 0; i < 8; i++) rf[i] = 16'h0000;
    rf[1] = 16'd3;
    rf[2] = 16'd4;
    rf[3] = 16'd7;

    @(negedge i_clk);
    checkEq("rst_valid", o_valid, 0);
    checkEq("rst_ready", o_ready, 1);
    checkEq("rst_result", o_result, 16'h0000);
    checkEq("rst_dstReg", o_dstReg, 0);
    checkEq("rst_wrEn", o_wrEn, 0);
    checkEq("rst_ccode", o_ccode, 3'b010);
    cycles(1);
    i_rst = 1'b0;
    cycles(1);

    // ADD 3+4, two-edge latency
    issue(OpAdd, 1'b0, 3'd1, 3'd2, 1'b0, 16'h0, 3'd0, 1'b1, 2'b00);
    checkEq("lat_notyet", o_valid, 0);
    cycles(1);
    checkEq("lat_valid", o_valid, 1);
    checkEq("add_result", o_result, 16'h0007);
    checkEq("add_ccode", o_ccode, 3'b001);
    cycles(3);

    // Back-to-back dependents with stale regfile data
    issue(OpSub, 1'b0, 3'd3, 3'd0, 1'b1, 16'd2, 3'd1, 1'b1, 2'b00);       // r1 = 5
    issue(OpAdd, 1'b0, 3'd1, 3'd2, 1'b0, 16'h0, 3'd4, 1'b1, 2'b01);       // r4 = 9
    issue(OpXor, 1'b0, 3'd2, 3'd4, 1'b0, 16'h0, 3'd5, 1'b1, 2'b10);       // r5 = 13
    issue(OpAdd, 1'b0, 3'd5, 3'd5, 1'b1, 16'h0100, 3'd6, 1'b1, 2'b01);    // imm not bypassed
    cycles(4);

    // Zero and negative condition codes
    issue(OpSub, 1'b0, 3'd1, 3'd0, 1'b1, 16'd5, 3'd6, 1'b1, 2'b00);       // 0x0000
    issue(OpSub, 1'b0, 3'd6, 3'd0, 1'b1, 16'h8000, 3'd7, 1'b1, 2'b01);    // 0x8000
    cycles(4);

    // Stall with three items in flight
    i_ready = 1'b0;
    resA = aluModel(OpAdd, 1'b0, rf[1], rf[2]);
    fork
      begin
        issue(OpAdd, 1'b0, 3'd1, 3'd2, 1'b0, 16'h0, 3'd0, 1'b1, 2'b00);
        issue(OpOr, 1'b0, 3'd0, 3'd0, 1'b1, 16'h00F0, 3'd0, 1'b1, 2'b01);
        issue(OpShl, 1'b0, 3'd0, 3'd0, 1'b1, 16'd4, 3'd1, 1'b1, 2'b01);
      end
      begin
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        checkEq("stall_ready_low", o_ready, 0);
        checkEq("stall_valid", o_valid, 1);
        for (int k = 0; k < 3; k++) begin
          checkEq("stall_result_hold", o_result, resA);
          @(negedge i_clk);
        end
        checkEq("stall_ready_still_low", o_ready, 0);
        @(posedge i_clk);
        #1;
        i_ready = 1'b1;
      end
    join
    cycles(5);

    // Flush with E occupied: W item survives, E item vanishes
    i_ready = 1'b0;
    resA = aluModel(OpAdd, 1'b0, rf[2], 16'd1);
    issue(OpAdd, 1'b0, 3'd2, 3'd0, 1'b1, 16'd1, 3'd3, 1'b1, 2'b00);
    issue(OpXor, 1'b0, 3'd2, 3'd2, 1'b0, 16'h0, 3'd5, 1'b0, 2'b00);
    i_valid = 1'b1;
    i_flush = 1'b1;
    cycles(1);
    i_valid = 1'b0;
    i_flush = 1'b0;
    void'(expQ.pop_back());
    @(negedge i_clk);
    checkEq("flush_ready", o_ready, 1);
    checkEq("flush_w_valid", o_valid, 1);
    checkEq("flush_w_result", o_result, resA);
    cycles(1);
    i_ready = 1'b1;
    cycles(5);
    checkEq("flush_drained", 32'(expQ.size()), 0);
    checkEq("flush_idle", o_valid, 0);

    // Reset in the middle of a stall
    i_ready = 1'b0;
    issue(OpAdd, 1'b0, 3'd2, 3'd3, 1'b0, 16'h0, 3'd4, 1'b0, 2'b00);
    issue(OpSub, 1'b0, 3'd2, 3'd3, 1'b0, 16'h0, 3'd4, 1'b0, 2'b00);
    i_rst = 1'b1;
    @(negedge i_clk);
    checkEq("midrst_valid", o_valid, 0);
    checkEq("midrst_ready", o_ready, 1);
    checkEq("midrst_result", o_result, 16'h0000);
    checkEq("midrst_ccode", o_ccode, 3'b010);
    expQ.delete();
    cycles(1);
    i_rst = 1'b0;
    i_ready = 1'b1;
    cycles(5);
    checkEq("midrst_no_item", o_valid, 0);

    checkEq("queue_empty", 32'(expQ.size()), 0);
    checkEq("delivered", delivered, 11);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state on its rising edge.
REQ-002 SHALL have port i_rst, input, 1, reset, asynchronous, active-high.
REQ-003 SHALL have decode-side inputs i_valid (1), i_opcode (3), i_flagBit (1), i_src1Reg (3), i_src2Reg (3), i_useImm (1), i_imm (16), i_dstReg (3), i_wrEn (1), i_src1Data (16), i_src2Data (16), i_flush (1), and output o_ready (1).
REQ-004 SHALL have ALU-side outputs o_aluSrc1 (16), o_aluSrc2 (16), o_aluOpcode (3), o_aluFlagBit (1), and input i_aluResult (16), the combinational ALU result.
REQ-005 SHALL have writeback-side outputs o_valid (1), o_result (16), o_dstReg (3), o_wrEn (1), o_ccode (3, {N,Z,P}), and input i_ready (1).

Function
REQ-006 SHALL hold two stages: E (latched operands, register numbers, opcode, flagBit, dst, wrEn, valid) and W (latched result, dst, wrEn, ccode, valid).
REQ-007 SHALL define advE = E.valid & (~W.valid | i_ready); o_ready = ~E.valid | advE.
REQ-008 SHALL accept a decode item on an edge where i_valid & o_ready & ~i_flush; E loads it, src2 operand = i_useImm ? i_imm : i_src2Data.
REQ-009 SHALL on an edge with advE load W from E with the ALU result; E.valid clears unless a new item is accepted on the same edge.
REQ-010 SHALL on an edge with W.valid & i_ready & ~advE clear W.valid.
REQ-011 SHALL hold W and E unchanged while W.valid & ~i_ready (stall); o_result stable throughout.
REQ-012 SHALL drive o_aluSrc1/o_aluSrc2 from E operands, forwarding o_result in place of an operand when W.valid & W.wrEn & W.dstReg equals that operand's register number; src2 never forwarded if E captured an immediate.
REQ-013 SHALL drive o_aluOpcode and o_aluFlagBit directly from E.
REQ-014 SHALL compute W.ccode from the 16-bit result: N = bit15, Z = all-zero, P = ~N & ~Z; exactly one bit set.
REQ-015 SHALL give latency of 2 edges from acceptance to o_valid with no stalls; throughput 1 item/cycle.
REQ-016 SHALL on i_flush clear E.valid on the next edge and refuse acceptance that edge; W is unaffected (already committed).
REQ-017 SHALL ignore all decode data inputs when not accepting.

Reset
REQ-018 SHALL on i_rst clear E.valid, W.valid, o_wrEn, o_result (0x0000), o_dstReg (0), o_ccode (3'b010); o_ready = 1 after reset.
REQ-019 SHALL treat reset mid-operation as discard of both stages; no item emerges afterwards.

Structure
REQ-020 SHALL place opcode constants (ADD/SUB 00x, SET/XOR 01x, SHIFT 10x, OR/AND 11x) and ccode encodings in the shared core package.
REQ-021 SHALL contain one sub-module exe_fwd (operand forwarding compare-and-select, instanced per operand); the ALU stays external.

Verification
REQ-022 SHALL check: reset, then ADD 0x0003+0x0004, i_ready=1 -> o_valid 2 edges later, o_result 0x0007, o_ccode 3'b001.
REQ-023 SHALL check: SUB r1=5 then dependent ADD reading r1 back-to-back, regfile data stale 0 -> second result uses forwarded value.
REQ-024 SHALL check: i_ready=0 for 3 cycles with 3 items issued -> o_ready drops once E and W full, o_result stable, no item lost or duplicated.
REQ-025 SHALL check: i_flush with E full -> E item never appears; W item delivered.
REQ-026 SHALL check: SUB giving 0x0000 -> ccode 3'b010; 0x8000 -> 3'b100.
REQ-027 SHALL check: i_rst asserted mid-stall -> o_valid=0 next cycle, o_ready=1.
